// File: rtl/t_ff_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : t_ff_pkg
//  Purpose  : Shared helper for the toggle flip-flop bank.
//  Revision : 1.0  initial release
// ============================================================================
package t_ff_pkg;

    // Next-state of a single toggle bit: invert when t is set, hold otherwise.
    function automatic logic toggle_next(input logic q, input logic t);
        return q ^ t;
    endfunction

endpackage : t_ff_pkg
`default_nettype wire

// File: rtl/t_ff_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : t_ff_if
//  Purpose  : Bundles the toggle-enable and output vectors of a t_ff bank.
//             The master drives T and observes Q/Qa; the slave is the bank.
//  Revision : 1.0  initial release
// ============================================================================
interface t_ff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] T;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qa;

    modport master (output T, input  Q, input  Qa);
    modport slave  (input  T, output Q, output Qa);
endinterface : t_ff_if
`default_nettype wire

// File: rtl/t_ff_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : t_ff_cell
//  Purpose  : Single-bit toggle cell with asynchronous active-low reset.
//             q and qa are both registered in the same block so they can
//             never be seen with equal values.
//  Revision : 1.0  initial release
// ============================================================================
module t_ff_cell
    import t_ff_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic t,
    output logic      q,
    output logic      qa
);

    // Toggle on a rising edge when t is set; reset wins asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q  <= RST_BIT;
            qa <= ~RST_BIT;
        end else begin
            q  <= toggle_next(q, t);
            qa <= toggle_next(qa, t);
        end
    end

endmodule : t_ff_cell
`default_nettype wire

// File: rtl/t_ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : t_ff
//  Purpose  : Bank of WIDTH independent toggle flip-flops with complement
//             outputs. No carry between bits; ripple counters are built
//             outside by chaining Q into the next stage's clock.
//  Revision : 1.0  initial release
// ============================================================================
module t_ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] T,
    output wire logic [WIDTH-1:0] Q,
    output wire logic [WIDTH-1:0] Qa
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            t_ff_cell #(
                .RST_BIT (RESET_VAL[i])
            ) u_cell (
                .clk (clk),
                .rst (rst),
                .t   (T[i]),
                .q   (Q[i]),
                .qa  (Qa[i])
            );
        end
    endgenerate

`ifndef SYNTHESIS
    logic             chk_armed;
    logic             chk_past_valid;
    logic [WIDTH-1:0] past_q;
    logic [WIDTH-1:0] past_t;

    // Capture pre-edge Q and T so the following negedge can confirm the toggle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_armed      <= 1'b1;
            chk_past_valid <= 1'b0;
            past_q         <= '0;
            past_t         <= '0;
        end else begin
            chk_past_valid <= 1'b1;
            past_q         <= Q;
            past_t         <= T;
        end
    end

    // Check complement, reset value and toggle behaviour mid-cycle, once reset has been seen.
    always @(negedge clk) begin
        if (chk_armed === 1'b1) begin
            a_qa_inv: assert (Qa == ~Q)
                else $error("t_ff: Qa is not the complement of Q");
            if (!rst) begin
                a_rst_val: assert (Q == RESET_VAL)
                    else $error("t_ff: Q differs from RESET_VAL during reset");
            end else if (chk_past_valid) begin
                a_toggle: assert (Q == (past_q ^ past_t))
                    else $error("t_ff: Q did not follow the sampled T");
            end
        end
    end
`endif

endmodule : t_ff
`default_nettype wire

// File: tb/tb_t_ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_t_ff
//  Purpose  : Scoreboard bench for t_ff: a 1-bit bank and a 4-bit bank with
//             RESET_VAL 4'b1010 are driven side by side; expected values are
//             queued by the stimulus and popped by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_t_ff;

    localparam logic       RV1 = 1'b0;
    localparam logic [3:0] RV4 = 4'b1010;

    typedef struct {
        string      name;
        logic       e1;
        logic [3:0] e4;
    } exp_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst4;

    t_ff_if #(.WIDTH(1)) if1 ();
    t_ff_if #(.WIDTH(4)) if4 ();

    t_ff #(.WIDTH(1), .RESET_VAL(RV1)) dut1 (
        .clk (clk), .rst (rst1), .T (if1.T), .Q (if1.Q), .Qa (if1.Qa)
    );

    t_ff #(.WIDTH(4), .RESET_VAL(RV4)) dut4 (
        .clk (clk), .rst (rst4), .T (if4.T), .Q (if4.Q), .Qa (if4.Qa)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic       m1;
    logic [3:0] m4;
    event       chk_ev;

    task automatic compare(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // Monitor: after every rising edge or async event, check everything queued.
    initial begin
        forever begin
            @(posedge clk or chk_ev);
            #1;
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                compare({e.name, "/q1"},  {3'b000, if1.Q},  {3'b000, e.e1});
                compare({e.name, "/qa1"}, {3'b000, if1.Qa}, {3'b000, ~e.e1});
                compare({e.name, "/q4"},  if4.Q,  e.e4);
                compare({e.name, "/qa4"}, if4.Qa, ~e.e4);
            end
        end
    end

    task automatic push(input string n);
        exp_t e;
        e.name = n;
        e.e1   = m1;
        e.e4   = m4;
        sb.push_back(e);
    endtask

    // Directed cycle: called at a negedge, hand-computed result after next posedge.
    task automatic cycle(input string n, input logic t1, input logic [3:0] t4,
                         input logic e1, input logic [3:0] e4);
        if1.T = t1;
        if4.T = t4;
        m1 = e1;
        m4 = e4;
        push(n);
        @(negedge clk);
    endtask

    // Random cycle: reference model decides the result.
    task automatic rcycle(input string n, input logic t1, input logic [3:0] t4);
        if1.T = t1;
        if4.T = t4;
        m1 = rst1 ? (m1 ^ t1) : RV1;
        m4 = rst4 ? (m4 ^ t4) : RV4;
        push(n);
        @(negedge clk);
    endtask

    // Assert reset between edges and check outputs without a clock edge.
    task automatic async_rst(input string n, input bit r1, input bit r4);
        #2;
        if (r1) begin rst1 = 1'b0; m1 = RV1; end
        if (r4) begin rst4 = 1'b0; m4 = RV4; end
        push(n);
        -> chk_ev;
        #2;
    endtask

    task automatic release_rst(input bit r1, input bit r4);
        if (r1) rst1 = 1'b1;
        if (r4) rst4 = 1'b1;
    endtask

    initial begin
        rst1  = 1'b1;
        rst4  = 1'b1;
        if1.T = '0;
        if4.T = '0;

        // 1: reset before any clock edge, then hold through two edges
        async_rst("p1_async", 1, 1);
        @(negedge clk);
        cycle("p1_hold_a", 1'b0, 4'b0000, 1'b0, 4'b1010);
        cycle("p1_hold_b", 1'b1, 4'b1111, 1'b0, 4'b1010);

        // 2: release at a negedge, T=0 holds
        release_rst(1, 1);
        cycle("p2_idle_a", 1'b0, 4'b0000, 1'b0, 4'b1010);
        cycle("p2_idle_b", 1'b0, 4'b0000, 1'b0, 4'b1010);

        // 3: toggle twice, then hold
        cycle("p3_tog_a",  1'b1, 4'b0000, 1'b1, 4'b1010);
        cycle("p3_tog_b",  1'b1, 4'b0000, 1'b0, 4'b1010);
        cycle("p3_hold_a", 1'b0, 4'b0000, 1'b0, 4'b1010);
        cycle("p3_hold_b", 1'b0, 4'b0000, 1'b0, 4'b1010);

        // 4: three toggles, async reset, reset overrides a toggling edge
        cycle("p4_tog_a", 1'b1, 4'b0000, 1'b1, 4'b1010);
        cycle("p4_tog_b", 1'b1, 4'b0000, 1'b0, 4'b1010);
        cycle("p4_tog_c", 1'b1, 4'b0000, 1'b1, 4'b1010);
        async_rst("p4_async", 1, 0);
        cycle("p4_rst_ovr", 1'b1, 4'b0000, 1'b0, 4'b1010);
        release_rst(1, 0);

        // 5: multi-bit bank with non-zero reset value
        async_rst("p5_async", 0, 1);
        cycle("p5_in_rst", 1'b0, 4'b0101, 1'b0, 4'b1010);
        release_rst(0, 1);
        cycle("p5_tog",    1'b0, 4'b0110, 1'b0, 4'b1100);
        cycle("p5_hold_a", 1'b0, 4'b0000, 1'b0, 4'b1100);
        cycle("p5_hold_b", 1'b0, 4'b0000, 1'b0, 4'b1100);
        cycle("p5_all",    1'b1, 4'b1111, 1'b1, 4'b0011);

        // 6: random T with occasional async resets
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                bit r1;
                bit r4;
                r1 = 1'($urandom_range(0, 1));
                r4 = 1'($urandom_range(0, 1));
                if (!r1 && !r4) r1 = 1'b1;
                async_rst("p6_async", r1, r4);
                rcycle("p6_in_rst", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                release_rst(1, 1);
            end else begin
                rcycle("p6_rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
        end

        // Let the monitor drain, bounded
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_t_ff
`default_nettype wire
